// File: rtl/rv_configs.sv
// rtl/rv_configs.sv - shared branch func3 codes and BTB direction-counter constants
package rv_configs;

    // Conditional branch func3 encodings
    localparam logic [2:0] FUNC3_BEQ  = 3'b000;
    localparam logic [2:0] FUNC3_BNE  = 3'b001;
    localparam logic [2:0] FUNC3_BLT  = 3'b100;
    localparam logic [2:0] FUNC3_BGE  = 3'b101;
    localparam logic [2:0] FUNC3_BLTU = 3'b110;
    localparam logic [2:0] FUNC3_BGEU = 3'b111;

    // 2-bit saturating direction counter states
    localparam logic [1:0] BP_CTR_SNT = 2'b00;
    localparam logic [1:0] BP_CTR_WNT = 2'b01;
    localparam logic [1:0] BP_CTR_WT  = 2'b10;
    localparam logic [1:0] BP_CTR_ST  = 2'b11;

    // Saturating step of a direction counter toward the resolved outcome
    function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != BP_CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != BP_CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rv_branch_cond.sv
// rtl/rv_branch_cond.sv - combinational evaluation of a branch condition from func3
module rv_branch_cond
    import rv_configs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_func3,
    output logic            o_cond
);

    // func3 selects the comparison; reserved codes 010/011 never take
    always_comb begin
        o_cond = 1'b0;
        case (i_func3)
            FUNC3_BEQ:  o_cond = (i_a == i_b);
            FUNC3_BNE:  o_cond = (i_a != i_b);
            FUNC3_BLT:  o_cond = ($signed(i_a) <  $signed(i_b));
            FUNC3_BGE:  o_cond = ($signed(i_a) >= $signed(i_b));
            FUNC3_BLTU: o_cond = (i_a <  i_b);
            FUNC3_BGEU: o_cond = (i_a >= i_b);
            default:    o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_branch_predictor.sv
// rtl/rv_branch_predictor.sv - IF-stage BTB predictor with EX-stage resolution and perf counters
module rv_branch_predictor
    import rv_configs::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 64,
    parameter int IDX_W     = $clog2(BTB_DEPTH),
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [XLEN-1:0]  i_bp_pc_if,
    output logic             o_bp_pred_taken_if,
    output logic [XLEN-1:0]  o_bp_pred_target_if,
    input  logic [XLEN-1:0]  i_bp_a,
    input  logic [XLEN-1:0]  i_bp_b,
    input  logic [2:0]       i_bp_func3_ex,
    input  logic             i_bp_is_branch_ex,
    input  logic             i_bp_is_jump_ex,
    input  logic [XLEN-1:0]  i_bp_pc_ex,
    input  logic [XLEN-1:0]  i_bp_target_ex,
    input  logic             i_bp_pred_taken_ex,
    input  logic [XLEN-1:0]  i_bp_pred_target_ex,
    input  logic             i_bp_stall_ex,
    output logic             o_bp_flush_ifid,
    output logic [XLEN-1:0]  o_bp_redirect_pc,
    output logic [CNT_W-1:0] o_bp_cnt_branch,
    output logic [CNT_W-1:0] o_bp_cnt_mispred
);

    localparam int TAG_W = XLEN - IDX_W - 2;

    // BTB storage
    logic [BTB_DEPTH-1:0] valid_q;
    logic [BTB_DEPTH-1:0] jump_q;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [XLEN-1:0]      target_q [BTB_DEPTH];
    logic [1:0]           ctr_q    [BTB_DEPTH];

    logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             cond, actual_taken, res, mispredict;
    logic             btb_we;
    logic [1:0]       ctr_d;

    // Byte offset bits of both PCs carry no information for a 4-byte-aligned BTB
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_bp_pc_if[1:0], i_bp_pc_ex[1:0]};

    assign if_idx = i_bp_pc_if[IDX_W+1:2];
    assign if_tag = i_bp_pc_if[XLEN-1:IDX_W+2];
    assign ex_idx = i_bp_pc_ex[IDX_W+1:2];
    assign ex_tag = i_bp_pc_ex[XLEN-1:IDX_W+2];

    // Zero-latency fetch lookup; reads pre-edge contents so a same-cycle EX write shows next cycle
    always_comb begin
        if_hit              = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        o_bp_pred_taken_if  = 1'b0;
        o_bp_pred_target_if = '0;
        if (if_hit) begin
            o_bp_pred_taken_if  = jump_q[if_idx] || ctr_q[if_idx][1];
            o_bp_pred_target_if = target_q[if_idx];
        end
    end

    rv_branch_cond #(
        .XLEN (XLEN)
    ) u_cond (
        .i_a     (i_bp_a),
        .i_b     (i_bp_b),
        .i_func3 (i_bp_func3_ex),
        .o_cond  (cond)
    );

    // EX resolution: outcome, mispredict detection, redirect target and BTB write data
    always_comb begin
        actual_taken = i_bp_is_jump_ex || (i_bp_is_branch_ex && cond);
        res          = i_rstn && (i_bp_is_branch_ex || i_bp_is_jump_ex) && !i_bp_stall_ex;
        mispredict   = res && ((actual_taken != i_bp_pred_taken_ex) ||
                               (actual_taken && (i_bp_pred_target_ex != i_bp_target_ex)));
        o_bp_flush_ifid  = mispredict;
        o_bp_redirect_pc = actual_taken ? i_bp_target_ex : (i_bp_pc_ex + XLEN'(4));

        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        btb_we = res && (ex_hit || actual_taken);
        ctr_d  = ex_hit ? bp_ctr_next(ctr_q[ex_idx], actual_taken) : BP_CTR_WT;

        cnt_branch_d  = cnt_branch_q  + (res        ? CNT_W'(1) : CNT_W'(0));
        cnt_mispred_d = cnt_mispred_q + (mispredict ? CNT_W'(1) : CNT_W'(0));
    end

    // BTB update on resolution: train a hit, allocate on a taken miss
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q <= '0;
            jump_q  <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= BP_CTR_WNT;
            end
        end else if (btb_we) begin
            valid_q[ex_idx]  <= 1'b1;
            jump_q[ex_idx]   <= i_bp_is_jump_ex;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= i_bp_target_ex;
            ctr_q[ex_idx]    <= ctr_d;
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_branch_q  <= '0;
            cnt_mispred_q <= '0;
        end else begin
            cnt_branch_q  <= cnt_branch_d;
            cnt_mispred_q <= cnt_mispred_d;
        end
    end

    assign o_bp_cnt_branch  = cnt_branch_q;
    assign o_bp_cnt_mispred = cnt_mispred_q;

endmodule

// File: doc/rv_branch_predictor.md
Name: rv_branch_predictor

Overview:
Parametrised successor to the EX-stage branch comparator.
- Adds an IF-stage direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Resolves branches and jumps in EX against the prediction carried down the pipeline.
- Flushes IF/ID only on misprediction and supplies the corrected PC.
- Keeps branch and mispredict performance counters.

Parameters:
XLEN, 32, datapath/PC width
BTB_DEPTH, 64, number of BTB entries (power of 2, at least 2)
IDX_W, $clog2(BTB_DEPTH), index width (derived; do not override)
CNT_W, 32, performance counter width

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_bp_pc_if  in  XLEN  fetch PC
o_bp_pred_taken_if  out  1  predict taken at fetch
o_bp_pred_target_if  out  XLEN  predicted target; valid when pred_taken
i_bp_a  in  XLEN  rs1 operand (forwarded)
i_bp_b  in  XLEN  rs2 operand (forwarded)
i_bp_func3_ex  in  3  branch func3
i_bp_is_branch_ex  in  1  EX holds a conditional branch
i_bp_is_jump_ex  in  1  EX holds JAL/JALR
i_bp_pc_ex  in  XLEN  PC of EX instruction
i_bp_target_ex  in  XLEN  computed actual target
i_bp_pred_taken_ex  in  1  prediction made for this instruction at IF
i_bp_pred_target_ex  in  XLEN  target predicted at IF
i_bp_stall_ex  in  1  EX held; no update, no flush
o_bp_flush_ifid  out  1  mispredict: flush IF/ID
o_bp_redirect_pc  out  XLEN  PC to fetch when flush is 1
o_bp_cnt_branch  out  CNT_W  resolved branch/jump count
o_bp_cnt_mispred  out  CNT_W  mispredict count

Behaviour:
- BTB entry fields: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN], ctr[1:0], is_jump.
- Index = pc[IDX_W+1:2]. PC bits [1:0] are ignored.
- Reset (async, i_rstn=0): all valid=0, ctr=2'b01 (weakly not-taken), both perf counters=0, flush=0. Prediction outputs read 0/0 while all entries are invalid.
- Reset asserted mid-operation clears all state immediately. No pending update survives reset.
- IF lookup is combinational, zero latency.
  - hit = valid && tag match.
  - o_bp_pred_taken_if = hit && (is_jump || ctr[1]).
  - o_bp_pred_target_if = entry target when hit, else 0.
- EX condition (func3):
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
  - 010 and 011 evaluate as not taken.
- actual_taken = is_jump || (is_branch && cond).
- res = (is_branch || is_jump) && !stall.
- mispredict = res && ((actual_taken != pred_taken_ex) || (actual_taken && pred_target_ex != target_ex)).
- o_bp_flush_ifid = mispredict, combinational, same cycle as EX.
- o_bp_redirect_pc = actual_taken ? target_ex : pc_ex+4, wrapping mod 2^XLEN. Value is don't-care when flush=0 but driven deterministically.
- Update on rising edge when res:
  - Hit: ctr increments on taken, decrements on not-taken, saturating at 11/00. Target and is_jump are rewritten.
  - Miss and actual_taken: allocate/replace the entry. valid=1, tag, target, is_jump; ctr=2'b10 (weakly taken).
  - Miss and not taken: no write.
- Same-cycle IF read and EX write to the same index: IF sees the old contents (write visible next cycle).
- Perf counters:
  - o_bp_cnt_branch increments on every res.
  - o_bp_cnt_mispred increments on every mispredict.
  - Both wrap to 0 at 2^CNT_W-1+1. Registered: value is visible the cycle after the event.
- Non-branch, non-jump instructions in EX: no update, no flush, no count.

Decomposition:
- Shared config include (rv_configs) owns:
  - existing FUNC3_B* codes;
  - new constants BP_CTR_SNT=2'b00, BP_CTR_WNT=2'b01, BP_CTR_WT=2'b10, BP_CTR_ST=2'b11.
- One sub-module, rv_branch_cond: combinational func3 evaluation of a/b to cond.

Test Plan:
- Reset, then fetch pc=0x100 -> pred_taken=0, target=0, both counters 0.
- BEQ a=5 b=5 at pc_ex=0x100, target 0x140, pred_taken_ex=0 -> flush=1, redirect=0x140. Next cycle fetch 0x100 -> pred_taken=1, target=0x140; cnt_branch=1, cnt_mispred=1.
- Same branch resolved taken twice, then BNE a=b=7 (not taken) with pred_taken_ex=1 -> flush=1, redirect=0x104. ctr goes 11 then 10; fetch still predicts taken.
- BLT a=0xFFFFFFFF b=1 -> taken. BLTU same operands -> not taken. func3=010 -> not taken, no allocation.
- JALR at 0x200, predicted target 0x300, actual 0x380 -> flush=1, redirect=0x380, entry target updated. stall_ex=1 on the same inputs -> flush=0, no update, counters unchanged.
- Aliasing: pc 0x100 and 0x100+4*BTB_DEPTH, second taken -> replaces tag, first now misses. Async reset mid-stream -> all predictions 0 immediately.
